// File: rtl/rs232_rx.sv
`default_nettype none
// ============================================================================
// Module      : rs232_rx
// Description : UART 8N1 receiver. Oversamples the serial line on the system
//               clock, samples each bit at its midpoint and presents the
//               received byte with a one-cycle valid strobe. A low stop bit
//               raises a one-cycle frame_err pulse. A held-low line is then
//               absorbed until it returns high. Start-bit glitches shorter
//               than half a bit are rejected.
// Revision    : 1.0 - initial release
// ============================================================================
module rs232_rx #(
    parameter int CLK_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_data,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLK_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q;
    logic             rx_s_q;
    logic             rx_d_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;

    // Two-flop synchroniser plus a one-cycle delay for falling-edge detection.
    // All three flops reset to the idle-high level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= rx_data;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: edge detect, half-bit start qualification, mid-bit
    // data sampling and stop-bit check. Strobes default low every cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_d_q && !rx_s_q) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_M1) begin
                    if (rx_s_q) begin
                        // Line went back high before mid-start: glitch.
                        state_d = S_IDLE;
                    end else begin
                        cnt_d     = '0;
                        bit_idx_d = 3'd0;
                        state_d   = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        // Leaving at mid-stop-bit gives half a bit of margin
                        // to catch an immediately following start edge.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_BREAK: begin
                // Wait out a held-low line; only a return high re-arms IDLE.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rs232_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs232_rx
// Description : Self-checking bench for rs232_rx. Drives 8N1 frames on the
//               serial line and compares strobes and bytes against an
//               expected-byte queue built from the bytes sent.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_rx;

    localparam int CPB = 16;
    localparam int LAT = 2 + 1 + CPB / 2 + 9 * CPB;

    logic       clk;
    logic       rst;
    logic       rx_data;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int valid_cnt = 0;
    int fe_cnt    = 0;
    int both_hi   = 0;
    int cyc       = 0;
    int last_valid_cyc = 0;
    int start_cyc = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] last_good;

    rs232_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes away from the active edge.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            got_q.push_back(data);
        end
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (valid === 1'b1 && frame_err === 1'b1) both_hi <= both_hi + 1;
    end

    // Every stimulus task starts and ends 1 time unit after a rising edge.
    task automatic drive_bit(input logic v);
        rx_data = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_data = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_v);
    endtask

    task automatic test_reset;
        int activity;
        rst = 1'b1;
        rx_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h valid=%b frame_err=%b busy=%b, need 00 0 0 0",
                     data, valid, frame_err, busy);
        end
        rst = 1'b0;
        activity = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || valid !== 1'b0 || frame_err !== 1'b0) activity++;
        end
        checks++;
        if (activity != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d active cycles, need 0", activity);
        end
    endtask

    task automatic test_basic;
        int v0, f0, lat;
        v0 = valid_cnt;
        f0 = fe_cnt;
        send_frame(8'hA5, 1'b1);
        last_good = 8'hA5;
        lat = last_valid_cyc - start_cyc;
        checks++;
        if (valid_cnt != v0 + 1) begin
            errors++;
            $display("FAIL basic_count: %0d valid pulses, need 1", valid_cnt - v0);
        end
        checks++;
        if (got_q.size() == 0 || got_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL basic_byte: got %h (queue %0d), need a5",
                     (got_q.size() != 0) ? got_q[0] : 8'hxx, got_q.size());
        end
        got_q.delete();
        checks++;
        if (data !== 8'hA5 || fe_cnt != f0) begin
            errors++;
            $display("FAIL basic_data: data=%h fe=%0d, need a5 0", data, fe_cnt - f0);
        end
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            errors++;
            $display("FAIL basic_latency: %0d cycles, need %0d +/-1", lat, LAT);
        end
    endtask

    task automatic test_glitch;
        int v0, f0, saw_busy;
        v0 = valid_cnt;
        f0 = fe_cnt;
        saw_busy = 0;
        rx_data = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_data = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1) saw_busy++;
        end
        checks++;
        if (saw_busy == 0 || saw_busy > CPB) begin
            errors++;
            $display("FAIL glitch_busy: busy for %0d cycles, need 1..%0d", saw_busy, CPB);
        end
        checks++;
        if (busy !== 1'b0 || valid_cnt != v0 || fe_cnt != f0) begin
            errors++;
            $display("FAIL glitch_quiet: busy=%b valid=%0d fe=%0d, need 0 0 0",
                     busy, valid_cnt - v0, fe_cnt - f0);
        end
    endtask

    task automatic test_frame_error;
        int v0, f0;
        v0 = valid_cnt;
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        rx_data = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        idle(3 * CPB);
        checks++;
        if (fe_cnt != f0 + 1 || valid_cnt != v0) begin
            errors++;
            $display("FAIL ferr_pulses: frame_err=%0d valid=%0d, need 1 0",
                     fe_cnt - f0, valid_cnt - v0);
        end
        checks++;
        if (data !== last_good) begin
            errors++;
            $display("FAIL ferr_data_kept: data=%h, need %h", data, last_good);
        end
        send_frame(8'h81, 1'b1);
        idle(CPB);
        last_good = 8'h81;
        checks++;
        if (valid_cnt != v0 + 1 || got_q.size() != 1 || data !== 8'h81) begin
            errors++;
            $display("FAIL ferr_recover: valid=%0d queue=%0d data=%h, need 1 1 81",
                     valid_cnt - v0, got_q.size(), data);
        end
        got_q.delete();
    endtask

    task automatic test_back_to_back;
        logic [7:0] pat [3];
        int f0;
        logic [7:0] g;
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h55;
        f0 = fe_cnt;
        for (int i = 0; i < 3; i++) begin
            send_frame(pat[i], 1'b1);
            exp_q.push_back(pat[i]);
        end
        idle(CPB);
        last_good = 8'h55;
        checks++;
        if (got_q.size() != 3 || fe_cnt != f0) begin
            errors++;
            $display("FAIL b2b_count: %0d bytes %0d frame_err, need 3 0", got_q.size(), fe_cnt - f0);
        end
        while (exp_q.size() != 0) begin
            g = (got_q.size() != 0) ? got_q.pop_front() : 8'hxx;
            checks++;
            if (g !== exp_q[0]) begin
                errors++;
                $display("FAIL b2b_byte: got %h, need %h", g, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        got_q.delete();
    endtask

    task automatic test_reset_midframe;
        int v0, f0;
        logic [7:0] b;
        b = 8'h7E;
        v0 = valid_cnt;
        f0 = fe_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(b[i]);
        rx_data = b[3];
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: busy=%b, need 1", busy);
        end
        rst = 1'b1;
        rx_data = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b data=%h valid=%b ferr=%b, need 0 00 0 0",
                     busy, data, valid, frame_err);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(12 * CPB);
        checks++;
        if (valid_cnt != v0 || fe_cnt != f0) begin
            errors++;
            $display("FAIL midrst_no_strobe: valid=%0d ferr=%0d, need 0 0", valid_cnt - v0, fe_cnt - f0);
        end
        send_frame(8'h12, 1'b1);
        idle(CPB);
        last_good = 8'h12;
        checks++;
        if (got_q.size() != 1 || data !== 8'h12) begin
            errors++;
            $display("FAIL midrst_next: queue=%0d data=%h, need 1 12", got_q.size(), data);
        end
        got_q.delete();
    endtask

    task automatic test_random;
        int f0, exp_fe, gap;
        logic [7:0] b, g;
        logic stop_v;
        f0 = fe_cnt;
        exp_fe = 0;
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            send_frame(b, stop_v);
            if (stop_v) begin
                exp_q.push_back(b);
                last_good = b;
                gap = $urandom_range(0, 20);
            end else begin
                exp_fe++;
                gap = CPB + $urandom_range(0, 20);
            end
            if (gap != 0) idle(gap);
        end
        idle(2 * CPB);
        checks++;
        if (fe_cnt - f0 != exp_fe || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_counts: ferr=%0d bytes=%0d, need %0d %0d",
                     fe_cnt - f0, got_q.size(), exp_fe, exp_q.size());
        end
        while (exp_q.size() != 0) begin
            g = (got_q.size() != 0) ? got_q.pop_front() : 8'hxx;
            checks++;
            if (g !== exp_q[0]) begin
                errors++;
                $display("FAIL rand_byte: got %h, need %h", g, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        checks++;
        if (data !== last_good) begin
            errors++;
            $display("FAIL rand_last_data: data=%h, need %h", data, last_good);
        end
        got_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        rx_data = 1'b1;
        last_good = 8'h00;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        checks++;
        if (both_hi != 0) begin
            errors++;
            $display("FAIL excl_strobes: %0d cycles with valid and frame_err, need 0", both_hi);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
